inst_decoder: RTL and testbench
===============================

# inst_decoder

Core-side responder for the 64-bit instruction word that the sequencer drives into `core` every cycle. It registers the word and slices it into per-unit control strobes for the xmem SRAM, L0, IFIFO, OFIFO, PE array, SFU and psum SRAM. It owns the psum read-modify-write timing: a read is issued now and the matching write-back one cycle later. It also counts OFIFO pops and runs a sticky protocol checker.

## Interface
- `INST_W`, 64: instruction word width.
- `ADDR_W`, 11: xmem/pmem address width.
- `CNT_W`, 8: OFIFO pop counter width.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `inst` in INST_W: instruction word, sampled every edge.
- `ofifo_valid` in 1: OFIFO holds a complete row.
- `load`, `execute`, `l0_wr`, `l0_rd`, `ififo_rd`, `ififo_wr`, `ofifo_rd` out 1: registered strobes.
- `xmem_cen`, `xmem_wen` out 1: xmem enables, active-low.
- `xmem_addr` out ADDR_W: xmem address.
- `pmem_cen` out 1: psum read enable, active-low.
- `pmem_addr` out ADDR_W: psum read address.
- `pmem_wr_en` out 1: write-back strobe, active-high.
- `pmem_wr_addr` out ADDR_W: write-back address.
- `acc`, `sfu_passthrough`, `pmem_ren`, `debug` out 1: SFU/psum mode bits.
- `acc_fwd` out 1: a read hits the pending write address.
- `pop_cnt` out CNT_W: OFIFO pops since reset.
- `err` out 1: sticky protocol error.
- `err_code` out 3: first error seen.

## Operation
- Bit map: [0] load, [1] execute, [2] l0_wr, [3] l0_rd, [4] ififo_rd, [5] ififo_wr, [6] ofifo_rd, [17:7] A_xmem, [18] WEN_xmem, [19] CEN_xmem, [30:20] A_pmem, [31] WEN_pmem, [32] CEN_pmem, [33] acc, [34] sfu_passthrough, [35] REN_pmem, [63] debug. Bits [62:36] are reserved and must be zero.
- Stage 1 registers every field. `WEN_pmem` is not forwarded directly; it arms the write-back.
- Write-back arms when `CEN_pmem`=0 and `WEN_pmem`=1. One cycle later `pmem_wr_en`=1 and `pmem_wr_addr` = that A_pmem.
- `acc_fwd`=1 when `pmem_cen`=0 and `pmem_addr` equals a `pmem_wr_addr` that is valid in the same cycle.
- `pop_cnt` increments on each registered `ofifo_rd`=1 and wraps 2^CNT_W-1 -> 0.
- Errors: the first one latches `err`=1 and `err_code`. Later errors do not overwrite it; only `reset` clears it. Codes, by priority:
  - 1: ofifo_rd while !ofifo_valid.
  - 2: load & execute.
  - 3: CEN_xmem=0 & WEN_xmem=0 & l0_wr.
  - 4: CEN_pmem=0 & acc & sfu_passthrough.
  - 5: reserved bit nonzero.
- Simultaneous errors record the lowest code.

## Timing
- Reset values:
  - All strobes, `acc`, `sfu_passthrough`, `pmem_ren`, `debug`, `pmem_wr_en`, `acc_fwd`, `err` = 0.
  - `xmem_cen`, `xmem_wen`, `pmem_cen` = 1.
  - Addresses, `pop_cnt`, `err_code` = 0.
- Latency:
  - inst -> control outputs: 1 cycle.
  - inst -> `pmem_wr_en`/`pmem_wr_addr`: 2 cycles.
- Back-to-back accumulates sustain one per cycle; the write pipe needs no stall.
- Reset mid-stream takes effect immediately. A pending write-back is dropped and `pmem_wr_en` goes low asynchronously.
- The `ofifo_valid` check uses the same-cycle `ofifo_valid` against the unregistered `inst` bit.

## Configuration
- `INST_CHECK_EN` defined: checker is instantiated and `err`/`err_code` operate as above.
- `INST_CHECK_EN` undefined: no checker logic is built; `err` and `err_code` are tied to 0.
- Decode, write-back and `pop_cnt` are identical in both builds.

## Structure
- Package `core_inst_pkg`:
  - bit-position and field-width localparams;
  - enum `inst_err_e` (NONE=0, OFIFO_UNDERRUN=1, LOAD_EXEC=2, XMEM_L0_CONFLICT=3, ACC_PASS=4, RSVD=5).
- Sub-module `inst_checker`: combinational error detect plus the sticky latch. Instantiated only under `INST_CHECK_EN`.

## Test plan
- Reset: hold `reset` 10 cycles, release -> all outputs at reset values; `xmem_cen`=`xmem_wen`=`pmem_cen`=1.
- Field map: inst with A_xmem=0x400, CEN_xmem=0, l0_wr=1 -> next cycle `xmem_addr`=0x400, `xmem_cen`=0, `l0_wr`=1, everything else idle.
- Write-back: CEN_pmem=0, WEN_pmem=1, acc=1 at A_pmem 3, 4, 4 on consecutive cycles:
  - `pmem_wr_en` high 3 cycles with `pmem_wr_addr` 3, 4, 4;
  - `acc_fwd`=1 on the third read only.
- Pop counter: 256 ofifo_rd pulses with `ofifo_valid`=1 -> `pop_cnt` returns to 0; `err`=0.
- Errors: ofifo_rd=1 with `ofifo_valid`=0, then load=execute=1 -> `err`=1, `err_code`=1 stays; pulse reset -> `err`=0.
- Reset mid-write: assert `reset` the cycle after an armed write -> `pmem_wr_en` never pulses.

Source files
------------

// File: rtl/core_inst_pkg.sv
// Shared field layout, widths and error codes for the core instruction word.
package core_inst_pkg;

   localparam int unsigned INST_W = 64;
   localparam int unsigned ADDR_W = 11;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned RSVD_W = 27;
   localparam int unsigned ERR_W  = 3;

   localparam int unsigned BIT_WEN_XMEM = 18;
   localparam int unsigned BIT_CEN_XMEM = 19;
   localparam int unsigned BIT_CEN_PMEM = 32;

   typedef enum logic [ERR_W-1:0] {
      NONE             = 3'd0,
      OFIFO_UNDERRUN   = 3'd1,
      LOAD_EXEC        = 3'd2,
      XMEM_L0_CONFLICT = 3'd3,
      ACC_PASS         = 3'd4,
      RSVD             = 3'd5
   } inst_err_e;

   // MSB-first layout of the 64-bit instruction word
   typedef struct packed {
      logic              debug;
      logic [RSVD_W-1:0] rsvd;
      logic              ren_pmem;
      logic              sfu_pass;
      logic              acc;
      logic              cen_pmem;
      logic              wen_pmem;
      logic [ADDR_W-1:0] a_pmem;
      logic              cen_xmem;
      logic              wen_xmem;
      logic [ADDR_W-1:0] a_xmem;
      logic              ofifo_rd;
      logic              ififo_wr;
      logic              ififo_rd;
      logic              l0_rd;
      logic              l0_wr;
      logic              execute;
      logic              load;
   } inst_t;

   // Idle word: everything off, active-low enables deasserted
   localparam logic [INST_W-1:0] INST_IDLE = (INST_W'(1) << BIT_WEN_XMEM)
                                           | (INST_W'(1) << BIT_CEN_XMEM)
                                           | (INST_W'(1) << BIT_CEN_PMEM);

endpackage

// File: rtl/inst_checker.sv
// Protocol checker: same-cycle error detect with a sticky first-error latch.
module inst_checker
   import core_inst_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ofifo_valid_i,
   input  logic              ofifo_rd_i,
   input  logic              load_i,
   input  logic              execute_i,
   input  logic              l0_wr_i,
   input  logic              cen_xmem_i,
   input  logic              wen_xmem_i,
   input  logic              cen_pmem_i,
   input  logic              acc_i,
   input  logic              sfu_pass_i,
   input  logic [RSVD_W-1:0] rsvd_i,
   output logic              err_o,
   output logic [ERR_W-1:0]  err_code_o
);

   inst_err_e code_d;
   inst_err_e code_q;
   logic      err_q;

   // Priority chain: lowest code wins when several fire together
   always_comb begin
      code_d = NONE;
      if (ofifo_rd_i && !ofifo_valid_i)                 code_d = OFIFO_UNDERRUN;
      else if (load_i && execute_i)                     code_d = LOAD_EXEC;
      else if (!cen_xmem_i && !wen_xmem_i && l0_wr_i)   code_d = XMEM_L0_CONFLICT;
      else if (!cen_pmem_i && acc_i && sfu_pass_i)      code_d = ACC_PASS;
      else if (|rsvd_i)                                 code_d = RSVD;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q  <= 1'b0;
         code_q <= NONE;
      end else if (!err_q && (code_d != NONE)) begin
         err_q  <= 1'b1;
         code_q <= code_d;
      end
   end

   assign err_o      = err_q;
   assign err_code_o = code_q;

endmodule

// File: rtl/inst_decoder.sv
// Registers the sequencer instruction word into per-unit strobes, times psum write-back,
// counts OFIFO pops. Protocol checker is built only when INST_CHECK_EN is defined.
module inst_decoder
   import core_inst_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [INST_W-1:0] inst,
   input  logic              ofifo_valid,
   output logic              load,
   output logic              execute,
   output logic              l0_wr,
   output logic              l0_rd,
   output logic              ififo_rd,
   output logic              ififo_wr,
   output logic              ofifo_rd,
   output logic              xmem_cen,
   output logic              xmem_wen,
   output logic [ADDR_W-1:0] xmem_addr,
   output logic              pmem_cen,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic              pmem_wr_en,
   output logic [ADDR_W-1:0] pmem_wr_addr,
   output logic              acc,
   output logic              sfu_passthrough,
   output logic              pmem_ren,
   output logic              debug,
   output logic              acc_fwd,
   output logic [CNT_W-1:0]  pop_cnt,
   output logic              err,
   output logic [ERR_W-1:0]  err_code
);

   inst_t              inst_s;
   inst_t              inst_q;
   logic               arm_d, arm_q;
   logic               wr_en_q;
   logic [ADDR_W-1:0]  wr_addr_d, wr_addr_q;
   logic               acc_fwd_d, acc_fwd_q;
   logic [CNT_W-1:0]   pop_cnt_d, pop_cnt_q;
   logic               unused_ok;

   assign inst_s = inst_t'(inst);

   // A read-with-write-back arms now and lands one cycle after the read is presented
   assign arm_d     = !inst_s.cen_pmem && inst_s.wen_pmem;
   assign wr_addr_d = arm_q ? inst_q.a_pmem : wr_addr_q;
   // Next-cycle read address matches next-cycle write-back address
   assign acc_fwd_d = !inst_s.cen_pmem && arm_q && (inst_s.a_pmem == inst_q.a_pmem);
   assign pop_cnt_d = pop_cnt_q + CNT_W'(inst_q.ofifo_rd);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst_q    <= inst_t'(INST_IDLE);
         arm_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         acc_fwd_q <= 1'b0;
         pop_cnt_q <= '0;
      end else begin
         inst_q    <= inst_s;
         arm_q     <= arm_d;
         wr_en_q   <= arm_q;
         wr_addr_q <= wr_addr_d;
         acc_fwd_q <= acc_fwd_d;
         pop_cnt_q <= pop_cnt_d;
      end
   end

   assign load            = inst_q.load;
   assign execute         = inst_q.execute;
   assign l0_wr           = inst_q.l0_wr;
   assign l0_rd           = inst_q.l0_rd;
   assign ififo_rd        = inst_q.ififo_rd;
   assign ififo_wr        = inst_q.ififo_wr;
   assign ofifo_rd        = inst_q.ofifo_rd;
   assign xmem_cen        = inst_q.cen_xmem;
   assign xmem_wen        = inst_q.wen_xmem;
   assign xmem_addr       = inst_q.a_xmem;
   assign pmem_cen        = inst_q.cen_pmem;
   assign pmem_addr       = inst_q.a_pmem;
   assign pmem_wr_en      = wr_en_q;
   assign pmem_wr_addr    = wr_addr_q;
   assign acc             = inst_q.acc;
   assign sfu_passthrough = inst_q.sfu_pass;
   assign pmem_ren        = inst_q.ren_pmem;
   assign debug           = inst_q.debug;
   assign acc_fwd         = acc_fwd_q;
   assign pop_cnt         = pop_cnt_q;

   assign unused_ok = ^{ofifo_valid, inst_q.rsvd, inst_q.wen_pmem};

`ifdef INST_CHECK_EN
   inst_checker u_checker (
      .clk_i         (clk),
      .rst_i         (reset),
      .ofifo_valid_i (ofifo_valid),
      .ofifo_rd_i    (inst_s.ofifo_rd),
      .load_i        (inst_s.load),
      .execute_i     (inst_s.execute),
      .l0_wr_i       (inst_s.l0_wr),
      .cen_xmem_i    (inst_s.cen_xmem),
      .wen_xmem_i    (inst_s.wen_xmem),
      .cen_pmem_i    (inst_s.cen_pmem),
      .acc_i         (inst_s.acc),
      .sfu_pass_i    (inst_s.sfu_pass),
      .rsvd_i        (inst_s.rsvd),
      .err_o         (err),
      .err_code_o    (err_code)
   );
`else
   assign err      = 1'b0;
   assign err_code = '0;
`endif

endmodule

// File: tb/tb_inst_decoder.sv
// Directed self-checking bench for inst_decoder; error expectations follow INST_CHECK_EN.
module tb_inst_decoder;

   localparam logic [63:0] IDLE = 64'h0000_0001_000C_0000;

   logic        clk;
   logic        reset;
   logic [63:0] inst;
   logic        ofifo_valid;
   logic        load, execute, l0_wr, l0_rd, ififo_rd, ififo_wr, ofifo_rd;
   logic        xmem_cen, xmem_wen, pmem_cen, pmem_wr_en;
   logic [10:0] xmem_addr, pmem_addr, pmem_wr_addr;
   logic        acc, sfu_passthrough, pmem_ren, debug, acc_fwd, err;
   logic [7:0]  pop_cnt;
   logic [2:0]  err_code;

   int checks   = 0;
   int failures = 0;

   inst_decoder dut (
      .clk             (clk),
      .reset           (reset),
      .inst            (inst),
      .ofifo_valid     (ofifo_valid),
      .load            (load),
      .execute         (execute),
      .l0_wr           (l0_wr),
      .l0_rd           (l0_rd),
      .ififo_rd        (ififo_rd),
      .ififo_wr        (ififo_wr),
      .ofifo_rd        (ofifo_rd),
      .xmem_cen        (xmem_cen),
      .xmem_wen        (xmem_wen),
      .xmem_addr       (xmem_addr),
      .pmem_cen        (pmem_cen),
      .pmem_addr       (pmem_addr),
      .pmem_wr_en      (pmem_wr_en),
      .pmem_wr_addr    (pmem_wr_addr),
      .acc             (acc),
      .sfu_passthrough (sfu_passthrough),
      .pmem_ren        (pmem_ren),
      .debug           (debug),
      .acc_fwd         (acc_fwd),
      .pop_cnt         (pop_cnt),
      .err             (err),
      .err_code        (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accumulating psum read with write-back at address a
   function automatic logic [63:0] pm(input logic [10:0] a);
      logic [63:0] w;
      w          = IDLE;
      w[32]      = 1'b0;
      w[31]      = 1'b1;
      w[33]      = 1'b1;
      w[30:20]   = a;
      return w;
   endfunction

   function automatic logic [2:0] exp_code(input logic [2:0] c);
`ifdef INST_CHECK_EN
      return c;
`else
      return 3'd0 & c;
`endif
   endfunction

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      check("err_clr", {61'd0, err, err_code}, 64'd0);
      reset = 1'b0;
      step();
   endtask

   logic [63:0] wb_in  [5];
   logic        wb_en  [5];
   logic [10:0] wb_a   [5];
   logic        wb_fwd [5];
   logic        wb_cen [5];
   logic [63:0] er_in  [5];
   logic        er_ov  [5];
   logic [2:0]  er_code[5];

   initial begin
      reset       = 1'b1;
      inst        = IDLE;
      ofifo_valid = 1'b0;
      repeat (10) step();

      // reset values, under reset and just after release
      for (int k = 0; k < 2; k++) begin
         check("rst_strobes", {57'd0, load, execute, l0_wr, l0_rd, ififo_rd, ififo_wr, ofifo_rd}, 64'd0);
         check("rst_cen", {61'd0, xmem_cen, xmem_wen, pmem_cen}, 64'd7);
         check("rst_addr", {31'd0, xmem_addr, pmem_addr, pmem_wr_addr}, 64'd0);
         check("rst_misc", {57'd0, acc, sfu_passthrough, pmem_ren, debug, pmem_wr_en, acc_fwd, err}, 64'd0);
         check("rst_cnt", {53'd0, pop_cnt, err_code}, 64'd0);
         reset = 1'b0;
         step();
      end

      // field map: xmem read at 0x400 with l0 write
      inst = 64'h0000_0001_0006_0004;
      step();
      inst = IDLE;
      check("fm_xmem_addr", 64'(xmem_addr), 64'h400);
      check("fm_enables", {61'd0, xmem_cen, xmem_wen, pmem_cen}, 64'b011);
      check("fm_strobes", {57'd0, ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load}, 64'b0000100);
      check("fm_idle", {58'd0, acc, sfu_passthrough, pmem_ren, debug, pmem_wr_en, err}, 64'd0);

      // back-to-back accumulates at 3, 4, 4
      wb_in  = '{pm(11'd3), pm(11'd4), pm(11'd4), IDLE, IDLE};
      wb_en  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      wb_a   = '{11'd0, 11'd3, 11'd4, 11'd4, 11'd0};
      wb_fwd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      wb_cen = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         inst = wb_in[i];
         step();
         check($sformatf("wb_en%0d", i), 64'(pmem_wr_en), 64'(wb_en[i]));
         if (wb_en[i]) check($sformatf("wb_addr%0d", i), 64'(pmem_wr_addr), 64'(wb_a[i]));
         check($sformatf("wb_fwd%0d", i), 64'(acc_fwd), 64'(wb_fwd[i]));
         check($sformatf("wb_cen%0d", i), 64'(pmem_cen), 64'(wb_cen[i]));
      end
      check("wb_acc_err", {62'd0, acc, err}, 64'd0);

      // pop counter: 255 pops, then one more wraps to zero
      ofifo_valid = 1'b1;
      inst = IDLE | 64'h40;
      repeat (255) step();
      inst = IDLE;
      step();
      step();
      check("pop_255", 64'(pop_cnt), 64'd255);
      inst = IDLE | 64'h40;
      step();
      inst = IDLE;
      step();
      step();
      check("pop_wrap", 64'(pop_cnt), 64'd0);
      check("pop_err", 64'(err), 64'd0);
      ofifo_valid = 1'b0;

      // sticky first error
      inst = IDLE | 64'h40;
      step();
      check("stk_first", {61'd0, err, err_code}, {61'd0, exp_code(3'd1) != 3'd0, exp_code(3'd1)});
      inst = IDLE | 64'h3;
      step();
      inst = IDLE;
      step();
      check("stk_hold", {61'd0, err, err_code}, {61'd0, exp_code(3'd1) != 3'd0, exp_code(3'd1)});
      pulse_reset();

      // individual codes and priority
      er_in   = '{IDLE | 64'h40, IDLE | 64'h0000_0100_0000_0003, 64'h0000_0001_0000_0004,
                  64'h0000_0006_000C_0000, IDLE | 64'h0000_0100_0000_0000};
      er_ov   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      er_code = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
      for (int i = 0; i < 5; i++) begin
         inst        = er_in[i];
         ofifo_valid = er_ov[i];
         step();
         inst        = IDLE;
         ofifo_valid = 1'b0;
         check($sformatf("code%0d", i + 1), {61'd0, err, err_code},
               {61'd0, exp_code(er_code[i]) != 3'd0, exp_code(er_code[i])});
         pulse_reset();
      end

      // reset the cycle after an armed write: write-back never pulses
      inst = pm(11'd7);
      step();
      inst  = IDLE;
      reset = 1'b1;
      #1;
      check("rmw_arm_rst", 64'(pmem_wr_en), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rmw_arm_%0d", i), 64'(pmem_wr_en), 64'd0);
         reset = 1'b0;
      end

      // reset while write-back is high drops it asynchronously
      inst = pm(11'd5);
      step();
      inst = IDLE;
      step();
      check("rmw_live", 64'(pmem_wr_en), 64'd1);
      reset = 1'b1;
      #1;
      check("rmw_async", 64'(pmem_wr_en), 64'd0);
      reset = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
